// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//  Shared definitions for the five-stage pipeline sequencer (pipe_ctrl) and
//  its helpers.
//
//  Contents
//   pc_state_e   : sequencer state encoding. The values are fixed because the
//                  fetch and decode blocks decode the same 2-bit codes.
//   NUM_STAGES   : number of pipeline stages (IF/ID/EXE/MEM/WB).
//   stage_allow  : allow-in term for one stage of the handshake chain.
//   fetch_open   : whether a state lets IF hand a new instruction to ID.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_RUN    = 2'd0,
      PC_DRAIN  = 2'd1,
      PC_HALTED = 2'd2,
      PC_STEP   = 2'd3
   } pc_state_e;

   localparam int unsigned NUM_STAGES = 5;

   // A stage can accept a new instruction when it is empty, or when its
   // current instruction finishes this cycle and the stage after it accepts.
   function automatic logic stage_allow(input logic valid,
                                        input logic over,
                                        input logic next_allow);
      return ~valid | (over & next_allow);
   endfunction

   // Only RUN and STEP let fetch hand instructions to ID. DRAIN and HALTED
   // keep the PC parked until the debugger says otherwise.
   function automatic logic fetch_open(input pc_state_e st);
      return (st == PC_RUN) || (st == PC_STEP);
   endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
//  Free-running unsigned event counter used for the pipeline performance
//  counters. Adds one on every clock where inc is high and wraps from
//  2^CNT_W-1 back to 0.
//
//  Ports
//   clk     in   1       clock
//   resetn  in   1       synchronous active-low reset, clears the count
//   inc     in   1       count this cycle
//   cnt     out  CNT_W   current count (registered)
// -----------------------------------------------------------------------------
module pipe_perf_cnt
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Plain modular add; wrap-around falls out of the fixed width.
   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//  Central sequencer for the five-stage pipeline (IF/ID/EXE/MEM/WB).
//  Owns the per-stage valid bits and the allow-in chain, decides when fetch
//  advances (next_fetch), flushes the pipe when WB takes an exception or
//  ERET, implements debug halt / drain / single-step, and keeps three
//  performance counters.
//
//  Ports
//   clk          in   1      clock
//   resetn       in   1      synchronous active-low reset
//   IF_over      in   1      IF holds a valid instruction on its output bus
//   ID_over      in   1      ID done (ID drops it itself on load-use stall)
//   EXE_over     in   1      EXE done (low while a mult/div is running)
//   MEM_over     in   1      MEM done
//   WB_over      in   1      WB done
//   exc_valid    in   1      exception or ERET taken in WB
//   halt_req     in   1      debug halt request, level sensitive
//   step         in   1      debug single-step pulse, used only when halted
//   IF_valid     out  1      IF stage valid
//   ID_valid     out  1      ID stage valid
//   EXE_valid    out  1      EXE stage valid
//   MEM_valid    out  1      MEM stage valid
//   WB_valid     out  1      WB stage valid
//   next_fetch   out  1      fetch loads next_pc on this edge (combinational)
//   halted       out  1      sequencer is parked in HALTED
//   perf_cycle   out  CNT_W  cycles since reset
//   perf_retire  out  CNT_W  instructions retired
//   perf_stall   out  CNT_W  cycles where IF was valid but fetch did not move
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             IF_over,
   input  logic             ID_over,
   input  logic             EXE_over,
   input  logic             MEM_over,
   input  logic             WB_over,
   input  logic             exc_valid,
   input  logic             halt_req,
   input  logic             step,
   output logic             IF_valid,
   output logic             ID_valid,
   output logic             EXE_valid,
   output logic             MEM_valid,
   output logic             WB_valid,
   output logic             next_fetch,
   output logic             halted,
   output logic [CNT_W-1:0] perf_cycle,
   output logic [CNT_W-1:0] perf_retire,
   output logic [CNT_W-1:0] perf_stall
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   pc_state_e state_q;
   pc_state_e state_d;

   logic if_valid_q;
   logic id_valid_q;
   logic exe_valid_q;
   logic mem_valid_q;
   logic wb_valid_q;
   logic halted_q;

   logic if_valid_d;
   logic id_valid_d;
   logic exe_valid_d;
   logic mem_valid_d;
   logic wb_valid_d;
   logic halted_d;

   // ---------------------------------------------------------------------
   // Handshake chain
   // ---------------------------------------------------------------------
   logic wb_allow;
   logic mem_allow;
   logic exe_allow;
   logic id_allow;
   logic fetch_gate;
   logic if_go;
   logic pipe_empty;
   logic next_fetch_w;

   // WB never back-pressures: its result is committed every cycle.
   assign wb_allow  = 1'b1;
   assign mem_allow = stage_allow(mem_valid_q, MEM_over, wb_allow);
   assign exe_allow = stage_allow(exe_valid_q, EXE_over, mem_allow);
   assign id_allow  = stage_allow(id_valid_q,  ID_over,  exe_allow);

   assign fetch_gate = fetch_open(state_q);

   // The instruction sitting in IF moves to ID. A WB exception masks it:
   // that instruction is on the wrong path and fetch is redirected instead.
   assign if_go = if_valid_q & IF_over & fetch_gate & id_allow & ~exc_valid;

   // Exception redirect must load exc_pc even while drained or halted.
   // Gating with resetn keeps fetch quiet while the core is held in reset.
   assign next_fetch_w = resetn & (exc_valid | if_go);

   assign pipe_empty = ~id_valid_q & ~exe_valid_q & ~mem_valid_q & ~wb_valid_q;

   // ---------------------------------------------------------------------
   // Valid bits, one cycle per stage
   // ---------------------------------------------------------------------
   always_comb begin
      // Fetch always holds a PC once out of reset.
      if_valid_d  = 1'b1;
      id_valid_d  = id_allow  ? if_go                      : id_valid_q;
      exe_valid_d = exe_allow ? (id_valid_q  & ID_over)    : exe_valid_q;
      mem_valid_d = mem_allow ? (exe_valid_q & EXE_over)   : mem_valid_q;
      wb_valid_d  = mem_valid_q & MEM_over;

      // Flush everything younger than WB. The excepting instruction in WB
      // still retires this cycle, so WB simply does not reload.
      if (exc_valid) begin
         id_valid_d  = 1'b0;
         exe_valid_d = 1'b0;
         mem_valid_d = 1'b0;
         wb_valid_d  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Debug sequencer
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PC_RUN: begin
            if (halt_req) begin
               state_d = PC_DRAIN;
            end
         end
         PC_DRAIN: begin
            if (pipe_empty) begin
               state_d = PC_HALTED;
            end
         end
         PC_HALTED: begin
            // Dropping the halt request beats a simultaneous step.
            if (!halt_req) begin
               state_d = PC_RUN;
            end else if (step) begin
               state_d = PC_STEP;
            end
         end
         PC_STEP: begin
            // Leave as soon as the single instruction enters ID, so exactly
            // one instruction is admitted per step.
            if (if_go) begin
               state_d = PC_DRAIN;
            end
         end
         default: begin
            state_d = PC_RUN;
         end
      endcase
      halted_d = (state_d == PC_HALTED);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= PC_RUN;
         halted_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         id_valid_q  <= 1'b0;
         exe_valid_q <= 1'b0;
         mem_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         halted_q    <= halted_d;
         if_valid_q  <= if_valid_d;
         id_valid_q  <= id_valid_d;
         exe_valid_q <= exe_valid_d;
         mem_valid_q <= mem_valid_d;
         wb_valid_q  <= wb_valid_d;
      end
   end

   // ---------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------
   logic retire_inc;
   logic stall_inc;

   assign retire_inc = wb_valid_q & WB_over;
   assign stall_inc  = if_valid_q & ~next_fetch_w;

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_cycle (
      .clk    (clk),
      .resetn (resetn),
      .inc    (1'b1),
      .cnt    (perf_cycle)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_retire (
      .clk    (clk),
      .resetn (resetn),
      .inc    (retire_inc),
      .cnt    (perf_retire)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
      .clk    (clk),
      .resetn (resetn),
      .inc    (stall_inc),
      .cnt    (perf_stall)
   );

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign IF_valid   = if_valid_q;
   assign ID_valid   = id_valid_q;
   assign EXE_valid  = exe_valid_q;
   assign MEM_valid  = mem_valid_q;
   assign WB_valid   = wb_valid_q;
   assign halted     = halted_q;
   assign next_fetch = next_fetch_w;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//  Directed bench for pipe_ctrl built with 4-bit counters so wrap-around is
//  reached quickly. Each row of the stimulus table drives one cycle of inputs
//  and queues the outputs that must be visible during that cycle; a monitor
//  process pops the queue mid-cycle and compares.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn    = 1'b0;
   logic          IF_over   = 1'b1;
   logic          ID_over   = 1'b1;
   logic          EXE_over  = 1'b1;
   logic          MEM_over  = 1'b1;
   logic          WB_over   = 1'b1;
   logic          exc_valid = 1'b0;
   logic          halt_req  = 1'b0;
   logic          step      = 1'b0;
   logic          IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
   logic          next_fetch, halted;
   logic [CW-1:0] perf_cycle, perf_retire, perf_stall;

   pipe_ctrl #(.CNT_W(CW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .IF_over     (IF_over),
      .ID_over     (ID_over),
      .EXE_over    (EXE_over),
      .MEM_over    (MEM_over),
      .WB_over     (WB_over),
      .exc_valid   (exc_valid),
      .halt_req    (halt_req),
      .step        (step),
      .IF_valid    (IF_valid),
      .ID_valid    (ID_valid),
      .EXE_valid   (EXE_valid),
      .MEM_valid   (MEM_valid),
      .WB_valid    (WB_valid),
      .next_fetch  (next_fetch),
      .halted      (halted),
      .perf_cycle  (perf_cycle),
      .perf_retire (perf_retire),
      .perf_stall  (perf_stall)
   );

   typedef struct {
      string         tag;
      logic [1:0]    chk;   // [0] valids/next_fetch/halted, [1] counters
      logic [4:0]    vld;   // {IF,ID,EXE,MEM,WB}
      logic          nf;
      logic          hlt;
      logic [CW-1:0] cyc;
      logic [CW-1:0] ret;
      logic [CW-1:0] stl;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Input encodings {resetn, IF/ID/EXE/MEM/WB_over, exc_valid, halt_req, step}
   localparam logic [8:0] R0  = 9'b0_11111_000;
   localparam logic [8:0] N   = 9'b1_11111_000;
   localparam logic [8:0] EX0 = 9'b1_11011_000;
   localparam logic [8:0] EXC = 9'b1_11111_100;
   localparam logic [8:0] HLT = 9'b1_11111_010;
   localparam logic [8:0] HST = 9'b1_11111_011;
   localparam logic [8:0] ST1 = 9'b1_11111_001;
   localparam logic [8:0] RX  = 9'b0_11011_000;

   task automatic cyc(input string tag, input logic [8:0] in, input logic [1:0] chk,
                      input logic [4:0] vld, input logic nf, input logic hlt,
                      input int c, input int r, input int s);
      exp_t e;
      @(negedge clk);
      {resetn, IF_over, ID_over, EXE_over, MEM_over, WB_over, exc_valid, halt_req, step} = in;
      e.tag = tag;
      e.chk = chk;
      e.vld = vld;
      e.nf  = nf;
      e.hlt = hlt;
      e.cyc = CW'(c);
      e.ret = CW'(r);
      e.stl = CW'(s);
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag, input string what, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s.%s got %0h expected %0h", tag, what, act, req);
      end
   endtask

   // Monitor: mid-cycle, after inputs settle and well before the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk[0]) begin
               check(e.tag, "valids", int'({IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid}), int'(e.vld));
               check(e.tag, "next_fetch", int'(next_fetch), int'(e.nf));
               check(e.tag, "halted", int'(halted), int'(e.hlt));
            end
            if (e.chk[1]) begin
               check(e.tag, "perf_cycle", int'(perf_cycle), int'(e.cyc));
               check(e.tag, "perf_retire", int'(perf_retire), int'(e.ret));
               check(e.tag, "perf_stall", int'(perf_stall), int'(e.stl));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset and fill
      cyc("rst0",  R0,  2'b00, 5'b00000, 0, 0,  0,  0,  0);
      cyc("rst1",  R0,  2'b11, 5'b00000, 0, 0,  0,  0,  0);
      cyc("rst2",  R0,  2'b11, 5'b00000, 0, 0,  0,  0,  0);
      cyc("rel",   N,   2'b11, 5'b00000, 0, 0,  0,  0,  0);
      cyc("fill1", N,   2'b11, 5'b10000, 1, 0,  1,  0,  0);
      cyc("fill2", N,   2'b11, 5'b11000, 1, 0,  2,  0,  0);
      cyc("fill3", N,   2'b11, 5'b11100, 1, 0,  3,  0,  0);
      cyc("fill4", N,   2'b11, 5'b11110, 1, 0,  4,  0,  0);
      cyc("full",  N,   2'b11, 5'b11111, 1, 0,  5,  0,  0);
      cyc("ret1",  N,   2'b11, 5'b11111, 1, 0,  6,  1,  0);
      cyc("ret2",  N,   2'b11, 5'b11111, 1, 0,  7,  2,  0);
      // EXE busy for five cycles
      cyc("exe1",  EX0, 2'b11, 5'b11111, 0, 0,  8,  3,  0);
      cyc("exe2",  EX0, 2'b11, 5'b11101, 0, 0,  9,  4,  1);
      cyc("exe3",  EX0, 2'b11, 5'b11100, 0, 0, 10,  5,  2);
      cyc("exe4",  EX0, 2'b11, 5'b11100, 0, 0, 11,  5,  3);
      cyc("exe5",  EX0, 2'b11, 5'b11100, 0, 0, 12,  5,  4);
      cyc("exeok", N,   2'b11, 5'b11100, 1, 0, 13,  5,  5);
      cyc("refl1", N,   2'b11, 5'b11110, 1, 0, 14,  5,  5);
      cyc("cwrap", N,   2'b11, 5'b11111, 1, 0, 15,  5,  5);
      // exception flush
      cyc("exc",   EXC, 2'b11, 5'b11111, 1, 0,  0,  6,  5);
      cyc("flush", N,   2'b11, 5'b10000, 1, 0,  1,  7,  5);
      cyc("reid",  N,   2'b11, 5'b11000, 1, 0,  2,  7,  5);
      cyc("ref2",  N,   2'b11, 5'b11100, 1, 0,  3,  7,  5);
      cyc("ref3",  N,   2'b11, 5'b11110, 1, 0,  4,  7,  5);
      // halt with four in flight, then single step
      cyc("hreq",  HLT, 2'b11, 5'b11111, 1, 0,  5,  7,  5);
      cyc("drn1",  HLT, 2'b11, 5'b11111, 0, 0,  6,  8,  5);
      cyc("drn2",  HLT, 2'b11, 5'b10111, 0, 0,  7,  9,  6);
      cyc("drn3",  HLT, 2'b11, 5'b10011, 0, 0,  8, 10,  7);
      cyc("drn4",  HLT, 2'b11, 5'b10001, 0, 0,  9, 11,  8);
      cyc("drn5",  HLT, 2'b11, 5'b10000, 0, 0, 10, 12,  9);
      cyc("hlt",   HLT, 2'b11, 5'b10000, 0, 1, 11, 12, 10);
      cyc("stp",   HST, 2'b11, 5'b10000, 0, 1, 12, 12, 11);
      cyc("stpf",  HLT, 2'b11, 5'b10000, 1, 0, 13, 12, 12);
      cyc("stp1",  HLT, 2'b11, 5'b11000, 0, 0, 14, 12, 12);
      cyc("stp2",  HLT, 2'b11, 5'b10100, 0, 0, 15, 12, 13);
      cyc("stp3",  HLT, 2'b11, 5'b10010, 0, 0,  0, 12, 14);
      cyc("stp4",  HLT, 2'b11, 5'b10001, 0, 0,  1, 12, 15);
      cyc("stp5",  HLT, 2'b11, 5'b10000, 0, 0,  2, 13,  0);
      // step together with halt release: RUN wins
      cyc("rel_s", ST1, 2'b11, 5'b10000, 0, 1,  3, 13,  1);
      cyc("run1",  N,   2'b11, 5'b10000, 1, 0,  4, 13,  2);
      cyc("run2",  N,   2'b11, 5'b11000, 1, 0,  5, 13,  2);
      // reset in the middle of a stall
      cyc("stl",   EX0, 2'b11, 5'b11100, 0, 0,  6, 13,  2);
      cyc("rstst", RX,  2'b11, 5'b11100, 0, 0,  7, 13,  3);
      cyc("prst",  N,   2'b11, 5'b00000, 0, 0,  0,  0,  0);
      cyc("prst1", N,   2'b11, 5'b10000, 1, 0,  1,  0,  0);
      @(negedge clk);
      #4;
      check("end", "queue_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
